// File: rtl/smg_scan_decoder.sv
// -----------------------------------------------------------------------------
// smg_scan_decoder
//   Receive-side readback of a multiplexed, active-low seven-segment scan.
//   Samples the segment and digit-select buses, ignores scan transitions,
//   decodes each stable digit back into a hex nibble and publishes the
//   reconstructed 4-digit value once every complete scan frame.
//
// Ports
//   clk             system clock (same clock as the display driver)
//   rst             asynchronous active-low reset
//   row_scan_sig    segment bus, active-low, {dp,g,f,e,d,c,b,a}
//   column_scan_sig digit select, active-low one-hot, bit n -> value[4n+3:4n]
//   value           last published frame, digit 0 in the LSB nibble
//   dp              decimal point per digit, 1 = lit
//   frame_valid     one-cycle pulse when value/dp/seg_err update
//   value_changed   pulse with frame_valid when the value moved (or first frame)
//   seg_err         last published frame held an unrecognised segment pattern
//   stalled         no capture for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------

// Per-digit capture slot: holds the latest capture for one digit position of
// the frame being assembled. A capture always wins over a frame clear so a
// digit landing on the publish edge opens the next frame.
module smg_digit_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_en,
    input  logic       clr,
    input  logic [3:0] cap_nib,
    input  logic       cap_dp,
    input  logic       cap_bad,
    output logic [3:0] nib,
    output logic       dp_lit,
    output logic       seen,
    output logic       bad
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nib    <= 4'h0;
            dp_lit <= 1'b0;
            seen   <= 1'b0;
            bad    <= 1'b0;
        end else if (cap_en) begin
            nib    <= cap_nib;
            dp_lit <= cap_dp;
            seen   <= 1'b1;
            bad    <= cap_bad;
        end else if (clr) begin
            seen   <= 1'b0;
            bad    <= 1'b0;
        end
    end

endmodule

module smg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  row_scan_sig,
    input  logic [3:0]  column_scan_sig,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        value_changed,
    output logic        seg_err,
    output logic        stalled
);

    localparam int NUM_DIGITS = 4;
    localparam int SC_W       = $clog2(STABLE_CYCLES + 1);

    localparam logic [SC_W-1:0]  STABLE_MAX = SC_W'(STABLE_CYCLES);
    localparam logic [SC_W-1:0]  STABLE_PRE = SC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_PRE    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        WAIT_STABLE,
        CAPTURED
    } dwell_e;

    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
        logic       bad;
    } cap_t;

    // ------------------------------------------------------------------
    // Input stage and stability tracking
    // ------------------------------------------------------------------
    logic [7:0]      row_q, prev_row_q;
    logic [3:0]      col_q, prev_col_q;
    logic [SC_W-1:0] stab_cnt;
    logic            same;
    logic            cnt_hit;
    logic [3:0]      sel;
    logic            one_low;

    assign same    = (row_q == prev_row_q) && (col_q == prev_col_q);
    // Counter moves from STABLE_CYCLES-1 to STABLE_CYCLES on this edge.
    assign cnt_hit = same && (stab_cnt == STABLE_PRE);
    assign sel     = ~col_q;
    // Exactly one select line low: blanking and overlap are never captured.
    assign one_low = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q      <= 8'h00;
            col_q      <= 4'h0;
            prev_row_q <= 8'h00;
            prev_col_q <= 4'h0;
            stab_cnt   <= '0;
        end else begin
            row_q      <= row_scan_sig;
            col_q      <= column_scan_sig;
            prev_row_q <= row_q;
            prev_col_q <= col_q;
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != STABLE_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Dwell FSM: at most one capture per stable dwell
    // ------------------------------------------------------------------
    dwell_e state_q, state_d;
    logic   capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= WAIT_STABLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            WAIT_STABLE: begin
                if (cnt_hit && one_low) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                end
            end
            CAPTURED: begin
                if (!same)
                    state_d = WAIT_STABLE;
            end
            default: state_d = WAIT_STABLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Segment pattern decode (active-low {g..a})
    // ------------------------------------------------------------------
    cap_t cap;

    always_comb begin
        cap.nib = 4'h0;
        cap.bad = 1'b0;
        cap.dp  = ~row_q[7];
        case (row_q[6:0])
            7'h40: cap.nib = 4'h0;
            7'h79: cap.nib = 4'h1;
            7'h24: cap.nib = 4'h2;
            7'h30: cap.nib = 4'h3;
            7'h19: cap.nib = 4'h4;
            7'h12: cap.nib = 4'h5;
            7'h02: cap.nib = 4'h6;
            7'h78: cap.nib = 4'h7;
            7'h00: cap.nib = 4'h8;
            7'h10: cap.nib = 4'h9;
            7'h08: cap.nib = 4'hA;
            7'h03: cap.nib = 4'hB;
            7'h46: cap.nib = 4'hC;
            7'h21: cap.nib = 4'hD;
            7'h06: cap.nib = 4'hE;
            7'h0E: cap.nib = 4'hF;
            default: cap.bad = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][3:0] slot_nib;
    logic [NUM_DIGITS-1:0]      slot_dp;
    logic [NUM_DIGITS-1:0]      seen;
    logic [NUM_DIGITS-1:0]      bad;
    logic [CNT_W-1:0]           tmo_cnt;
    logic                       first_frame;
    logic                       publish;
    logic                       timeout_hit;
    logic                       frame_clr;

    assign publish     = &seen;
    // A capture on the would-be timeout edge keeps the scan alive.
    assign timeout_hit = !capture && (tmo_cnt == TMO_PRE);
    assign frame_clr   = publish || timeout_hit;

    for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_slot
        smg_digit_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .cap_en  (capture && sel[n]),
            .clr     (frame_clr),
            .cap_nib (cap.nib),
            .cap_dp  (cap.dp),
            .cap_bad (cap.bad),
            .nib     (slot_nib[n]),
            .dp_lit  (slot_dp[n]),
            .seen    (seen[n]),
            .bad     (bad[n])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value         <= 16'h0000;
            dp            <= 4'h0;
            seg_err       <= 1'b0;
            frame_valid   <= 1'b0;
            value_changed <= 1'b0;
            stalled       <= 1'b0;
            tmo_cnt       <= '0;
            first_frame   <= 1'b1;
        end else begin
            frame_valid   <= publish;
            value_changed <= publish && ((slot_nib != value) || first_frame);
            if (publish) begin
                value       <= slot_nib;
                dp          <= slot_dp;
                seg_err     <= |bad;
                first_frame <= 1'b0;
            end

            if (capture)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (capture)
                stalled <= 1'b0;
            else if (timeout_hit)
                stalled <= 1'b1;
        end
    end

endmodule

// File: tb/tb_smg_scan_decoder.sv
module tb_smg_scan_decoder;

    localparam int S   = 4;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  row_scan_sig = 8'hFF;
    logic [3:0]  column_scan_sig = 4'hF;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        frame_valid, value_changed, seg_err, stalled;

    smg_scan_decoder #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .row_scan_sig    (row_scan_sig),
        .column_scan_sig (column_scan_sig),
        .value           (value),
        .dp              (dp),
        .frame_valid     (frame_valid),
        .value_changed   (value_changed),
        .seg_err         (seg_err),
        .stalled         (stalled)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on whole dwells. A dwell of L cycles on a
    // one-hot-low column yields a capture if L >= S+1; the capture edge is
    // S+2 edges after the dwell was applied (input register + counting).
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic [3:0]  dpv;
        logic        err;
        logic        vc;
    } frame_t;

    logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    frame_t      fq[$];
    int          cap_q[$];
    logic [3:0]  m_nib [4];
    logic [3:0]  m_dp, m_seen, m_bad;
    logic        m_first;
    logic [15:0] m_lastval;
    int          m_last_cap;
    logic [11:0] prev_raw;

    // observed/published side
    int          seen_last;
    logic [15:0] p_val;
    logic [3:0]  p_dp;
    logic        p_err;
    bit          mon_en = 0;
    int          fv_obs = 0;
    logic        obs_vc = 1'b0;

    function automatic bit is_one_low(input logic [3:0] c);
        logic [3:0] z;
        z = ~c;
        return $countones(z) == 1;
    endfunction

    function automatic logic [4:0] decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (seg_tbl[i] == p) return {1'b1, 4'(i)};
        return 5'h00;
    endfunction

    task automatic model_cap(input int e, input logic [7:0] r, input logic [3:0] c);
        logic [4:0]  d;
        logic [15:0] v;
        int          n;
        frame_t      f;
        if (e - m_last_cap > TMO) begin
            m_seen = 4'h0;
            m_bad  = 4'h0;
        end
        m_last_cap = e;
        cap_q.push_back(e);
        n = 0;
        for (int i = 0; i < 4; i++) if (!c[i]) n = i;
        d = decode(r[6:0]);
        m_nib[n]  = d[4] ? d[3:0] : 4'h0;
        m_dp[n]   = ~r[7];
        m_seen[n] = 1'b1;
        m_bad[n]  = ~d[4];
        if (m_seen == 4'hF) begin
            v      = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            f.cyc  = e + 1;
            f.val  = v;
            f.dpv  = m_dp;
            f.err  = |m_bad;
            f.vc   = m_first || (v != m_lastval);
            fq.push_back(f);
            m_first   = 1'b0;
            m_lastval = v;
            m_seen    = 4'h0;
            m_bad     = 4'h0;
        end
    endtask

    task automatic dwell(input logic [7:0] r, input logic [3:0] c, input int len);
        row_scan_sig    = r;
        column_scan_sig = c;
        if (len >= S + 1 && is_one_low(c) && {r, c} != prev_raw)
            model_cap(cyc + S + 2, r, c);
        prev_raw = {r, c};
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [7:0] r0, r1, r2, r3);
        dwell(r0, 4'b1110, 10);
        dwell(r1, 4'b1101, 10);
        dwell(r2, 4'b1011, 10);
        dwell(r3, 4'b0111, 10);
    endtask

    task automatic rst_assert();
        rst = 1'b0;
        fq.delete();
        cap_q.delete();
        m_seen = 4'h0; m_bad = 4'h0; m_dp = 4'h0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_first = 1'b1; m_lastval = 16'h0;
        p_val = 16'h0; p_dp = 4'h0; p_err = 1'b0;
    endtask

    task automatic rst_release();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        m_last_cap = cyc;
        seen_last  = cyc;
        prev_raw   = 12'h000;
        mon_en     = 1;
    endtask

    // ------------------------------------------------------------------
    // Cycle monitor: compares every cycle against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst && mon_en) begin
            while (cap_q.size() > 0 && cap_q[0] <= cyc) seen_last = cap_q.pop_front();
            chk("stalled", stalled, (cyc - seen_last) >= TMO);
            if (frame_valid) begin
                fv_obs++;
                obs_vc = value_changed;
            end
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
                frame_t f;
                f = fq.pop_front();
                chk("frame_valid", frame_valid, 1);
                chk("value_changed", value_changed, f.vc);
                p_val = f.val; p_dp = f.dpv; p_err = f.err;
            end else begin
                chk("fv_idle", frame_valid, 0);
                chk("vc_idle", value_changed, 0);
            end
            chk("value", value, p_val);
            chk("dp", dp, p_dp);
            chk("seg_err", seg_err, p_err);
        end
    end

    int fv0;
    logic [7:0] r;
    logic [3:0] c;
    int len, kind;

    initial begin
        rst_assert();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 0);
        chk("rst_flags", {frame_valid, value_changed, seg_err, stalled}, 0);
        chk("rst_dp", dp, 0);
        rst_release();
        dwell(8'hFF, 4'hF, 5);

        // 1: basic frame, then identical repeat
        fv0 = fv_obs;
        scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
        chk("t1_frames", fv_obs - fv0, 1);
        chk("t1_value", value, 16'h1234);
        chk("t1_vc", obs_vc, 1);
        chk("t1_err", seg_err, 0);
        chk("t1_dp", dp, 0);
        fv0 = fv_obs;
        scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
        chk("t1r_frames", fv_obs - fv0, 1);
        chk("t1r_vc", obs_vc, 0);

        // 2: short glitch dwell must not be captured
        fv0 = fv_obs;
        dwell(8'h99, 4'b1110, 10);
        dwell(8'hC0, 4'b1110, 2);
        dwell(8'hB0, 4'b1101, 10);
        dwell(8'hA4, 4'b1011, 10);
        dwell(8'hF9, 4'b0111, 10);
        chk("t2_frames", fv_obs - fv0, 1);
        chk("t2_value", value, 16'h1234);

        // 3: bad pattern on digit 2, then clean frame
        scan(8'h99, 8'hB0, 8'hFF, 8'hF9);
        chk("t3_value", value, 16'h1034);
        chk("t3_err", seg_err, 1);
        scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
        chk("t3c_value", value, 16'h1234);
        chk("t3c_err", seg_err, 0);

        // 4: decimal point on digit 0
        scan(8'h19, 8'hB0, 8'hA4, 8'hF9);
        chk("t4_dp", dp, 4'b0001);
        chk("t4_nib", value[3:0], 4'h4);

        // 5: stall after a partial frame, then resume from digit 2
        dwell(8'h80, 4'b1110, 10);
        dwell(8'h80, 4'b1101, 10);
        dwell(8'hFF, 4'hF, 80);
        chk("t5_stall", stalled, 1);
        chk("t5_hold", value, 16'h1234);
        fv0 = fv_obs;
        dwell(8'hA4, 4'b1011, 10);
        chk("t5_unstall", stalled, 0);
        dwell(8'hF9, 4'b0111, 10);
        chk("t5_partial", fv_obs - fv0, 0);
        dwell(8'h99, 4'b1110, 10);
        dwell(8'hB0, 4'b1101, 10);
        chk("t5_frames", fv_obs - fv0, 1);
        chk("t5_value", value, 16'h1234);

        // 6: async reset mid-frame
        dwell(8'h80, 4'b1110, 10);
        dwell(8'hF8, 4'b1101, 10);
        dwell(8'hFF, 4'hF, 3);
        rst_assert();
        #1;
        chk("t6_value", value, 0);
        chk("t6_flags", {frame_valid, value_changed, seg_err, stalled}, 0);
        chk("t6_dp", dp, 0);
        repeat (2) @(posedge clk);
        rst_release();
        dwell(8'hFF, 4'hF, 5);
        scan(8'h80, 8'hF8, 8'h82, 8'h92);
        chk("t6_value2", value, 16'h5678);
        chk("t6_vc", obs_vc, 1);

        // randomized scan traffic, checked cycle by cycle by the monitor
        for (int i = 0; i < 300; i++) begin
            do begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    c   = 4'($urandom_range(0, 15));
                    r   = 8'($urandom_range(0, 255));
                    len = $urandom_range(1, S + 6);
                end else if (kind == 1) begin
                    c   = 4'hF;
                    r   = 8'($urandom_range(0, 255));
                    len = ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(1, 10);
                end else begin
                    c = ~(4'b0001 << $urandom_range(0, 3));
                    if ($urandom_range(0, 9) < 8)
                        r = {1'($urandom_range(0, 1)), seg_tbl[$urandom_range(0, 15)]};
                    else
                        r = 8'($urandom_range(0, 255));
                    len = $urandom_range(S + 1, S + 8);
                end
            end while ({r, c} == prev_raw);
            dwell(r, c, len);
        end
        dwell(8'hFF, 4'hF, 20);
        chk("drain", fq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/smg_scan_decoder.md
Name: smg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed seven-segment driver. It samples the segment bus (row_scan_sig) and the digit-select bus (column_scan_sig) and filters out scan transitions. It decodes each stable digit's segment pattern back into a hex nibble and publishes the reconstructed 4-digit value once per complete scan frame. It is used for on-board readback and self-check of the display path, with the same single clock as the driver.

Parameters:
STABLE_CYCLES, 4, consecutive identical sampled cycles required before a digit is captured (>=2)
TIMEOUT_CYCLES, 1000000, cycles without any capture before the scan is declared stalled
CNT_W, 20, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
row_scan_sig  in  8  segment bus, active-low, bit order {dp,g,f,e,d,c,b,a}
column_scan_sig  in  4  digit select, active-low one-hot; bit n low selects digit n (value[4n+3:4n])
value  out  16  last published frame, digit 0 = LSB nibble
dp  out  4  decimal-point state per digit, 1 = lit
frame_valid  out  1  one-cycle pulse when value/dp/seg_err update
value_changed  out  1  one-cycle pulse coincident with frame_valid when value differs from the previous frame, or on the first frame after reset
seg_err  out  1  last published frame contained an unrecognised segment pattern
stalled  out  1  scan timeout flag

Behaviour:
- Reset value of every output is 0. Internal state is also cleared: seen mask, bad mask, pending buffer, stability counter, timeout counter. A first_frame flag is set on reset.
- Reset asserted mid-frame discards all partial captures.
- Input stage: row and column are registered once, so all decisions use registered values (1-cycle input latency).
- Stability counter:
  - Resets to 0 whenever the registered {row,col} differs from the previous cycle's registered {row,col}.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture condition:
  - The counter reaches STABLE_CYCLES on this edge.
  - The column is exactly one bit low.
  - No capture has yet been made in this dwell.
  - The dwell flag clears when {row,col} changes, so each dwell yields at most one capture.
- A column that is all-high (blanking) or has multiple bits low is never captured.
- On capture into slot n:
  - pending[n] = decoded nibble.
  - pend_dp[n] = ~row[7].
  - seen[n] = 1.
  - bad[n] = 1 if row[6:0] is not in the decode table; the nibble is then 0.
  - A repeated slot before the frame completes overwrites the earlier capture (latest wins).
- Decode table, row[6:0] -> nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
- Frame publish happens on the edge after the capture that makes seen == 4'hF. On that edge:
  - value, dp and seg_err (= |bad) are loaded.
  - frame_valid = 1 for exactly one cycle.
  - value_changed = (new value != old value) | first_frame.
  - first_frame, seen and bad are cleared.
- A capture arriving on the publish edge starts the next frame.
- Timeout counter:
  - Cleared on every capture; otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES: stalled = 1, and seen and bad are cleared (the partial frame is discarded).
  - stalled clears on the next capture.
  - value, dp and seg_err hold their last published values while stalled.
- Simultaneous timeout and capture on the same edge: the capture wins, and stalled is not set.
- Implementation uses two processes: a dwell FSM (WAIT_STABLE -> CAPTURED on capture; CAPTURED -> WAIT_STABLE on input change) and frame assembly.

Test Plan:
1. Scan digits 0..3 with rows 99,B0,A4,F9 (digit 0 = 4), 10 cycles per dwell, STABLE_CYCLES=4 -> one frame_valid pulse, value=16'h1234, value_changed=1, seg_err=0, dp=0. Repeat the identical frame -> frame_valid=1, value_changed=0.
2. Insert a 2-cycle dwell of col 1110 / row C0 between valid dwells -> no capture; the published value is unaffected by the glitch.
3. Digit 2 row = FF -> value=16'h1034, seg_err=1. Next clean frame -> seg_err=0, value=16'h1234.
4. Digit 0 row = 19 (dp lit) -> dp=4'b0001, value[3:0]=4.
5. TIMEOUT_CYCLES=64; capture 2 digits, then hold column 1111 -> stalled=1 at 64 cycles after the last capture. Resume a full scan -> stalled=0 after the first capture, frame_valid only after 4 new captures.
6. Assert rst low after 2 captures of a frame -> all outputs 0 immediately (async). After release, a full frame 5678 -> value=16'h5678, value_changed=1.
